// File: rtl/sr_lock_arbiter.sv
// sr_lock_arbiter: round-robin owner of an external SR latch, sequenced by one-hot set/reset pulses with q feedback
module sr_lock_arbiter #(
  parameter int N = 4,
  parameter int HOLD_MAX = 16,
  parameter int ACK_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] rel,
  input  logic         lock_q,
  output logic         lock_set,
  output logic         lock_rst,
  output logic [N-1:0] grant,
  output logic         busy,
  output logic         timeout,
  output logic         fault
);
  localparam int W = $clog2(N);
  localparam logic [W-1:0] LAST = W'(N - 1);
  typedef enum logic [2:0] {INIT, IDLE, SET, HELD, CLR, FAULT} state_t;
  state_t state, nxt;
  logic [W-1:0] ptr, owner, win, idx;
  logic [15:0] hcnt;
  logic [7:0] acnt;
  logic found, rls, hold_to, ack_to, to;
  always_comb begin
    win = ptr;
    found = 1'b0;
    idx = ptr;
    for (int i = 0; i < N; i++) begin
      idx = (idx == LAST) ? '0 : idx + 1'b1;
      if (req[idx] && !found) begin
        win = idx;
        found = 1'b1;
      end
    end
    rls = rel[owner] | ~req[owner];
    hold_to = (HOLD_MAX > 0) && (hcnt == 16'(HOLD_MAX - 1));
    ack_to = acnt == 8'(ACK_MAX - 1);
    to = 1'b0;
    nxt = state;
    case (state)
      INIT: nxt = !lock_q ? IDLE : ack_to ? FAULT : INIT;
      IDLE: nxt = found ? SET : IDLE;
      SET: nxt = lock_q ? (req[owner] ? HELD : CLR) : ack_to ? FAULT : SET;
      HELD: begin
        nxt = (rls || hold_to) ? CLR : HELD;
        to = !rls && hold_to;
      end
      CLR: nxt = !lock_q ? IDLE : ack_to ? FAULT : CLR;
      default: nxt = FAULT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      ptr <= LAST;
      owner <= '0;
      hcnt <= '0;
      acnt <= '0;
      grant <= '0;
      lock_set <= 1'b0;
      lock_rst <= 1'b0;
      busy <= 1'b1;
      timeout <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= nxt;
      owner <= (state == IDLE && found) ? win : owner;
      ptr <= (state == CLR && nxt == IDLE) ? owner : ptr;
      hcnt <= (state == HELD && nxt == HELD) ? hcnt + 1'b1 : '0;
      acnt <= (nxt == state && (state == INIT || state == SET || state == CLR)) ? acnt + 1'b1 : '0;
      grant <= (nxt == HELD) ? {{(N-1){1'b0}}, 1'b1} << owner : '0;
      lock_set <= nxt == SET;
      lock_rst <= nxt == INIT || nxt == CLR;
      busy <= nxt != IDLE;
      timeout <= to;
      fault <= nxt == FAULT;
    end
  end
endmodule

// File: tb/tb_sr_lock_arbiter.sv
// tb_sr_lock_arbiter: randomized and directed checks of sr_lock_arbiter against a transaction-level model with an SR latch model
module tb_sr_lock_arbiter;
  localparam int N = 4;
  localparam int HOLD_MAX = 16;
  localparam int ACK_MAX = 4;
  localparam int P_INIT = 0, P_IDLE = 1, P_SET = 2, P_HELD = 3, P_CLR = 4, P_FAULT = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] rel = '0;
  logic latch_q = 1'b1;
  bit stuck = 1'b0;
  logic lock_set, lock_rst, busy, timeout, fault;
  logic [N-1:0] grant;
  int n_chk = 0;
  int n_err = 0;
  int m_ph, m_ptr, m_own, m_wait, m_held, nph;
  bit to, target;
  logic [N-1:0] e_grant;
  bit e_set, e_rst, e_busy, e_to, e_fault;
  sr_lock_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX), .ACK_MAX(ACK_MAX)) dut (
    .clk(clk), .rst(rst), .req(req), .rel(rel), .lock_q(latch_q),
    .lock_set(lock_set), .lock_rst(lock_rst), .grant(grant),
    .busy(busy), .timeout(timeout), .fault(fault)
  );
  always #5 clk = ~clk;
  function automatic bit bit_at(input logic [N-1:0] v, input int i);
    return |(v & (N'(1) << i));
  endfunction
  always @(posedge clk) begin
    to = 1'b0;
    if (rst) begin
      m_ph = P_INIT;
      m_ptr = N - 1;
      m_own = 0;
      m_wait = 0;
      m_held = 0;
      nph = P_INIT;
    end else begin
      nph = m_ph;
      case (m_ph)
        P_IDLE:
          for (int k = 1; k <= N; k++)
            if (nph == P_IDLE && bit_at(req, (m_ptr + k) % N)) begin
              m_own = (m_ptr + k) % N;
              nph = P_SET;
            end
        P_HELD: begin
          m_held++;
          if (bit_at(rel, m_own) || !bit_at(req, m_own)) nph = P_CLR;
          else if (HOLD_MAX > 0 && m_held == HOLD_MAX) begin
            nph = P_CLR;
            to = 1'b1;
          end
        end
        P_FAULT: nph = P_FAULT;
        default: begin
          target = (m_ph == P_SET);
          if (latch_q == target) begin
            nph = (m_ph == P_SET) ? (bit_at(req, m_own) ? P_HELD : P_CLR) : P_IDLE;
            if (m_ph == P_CLR) m_ptr = m_own;
          end else begin
            m_wait++;
            if (m_wait == ACK_MAX) nph = P_FAULT;
          end
        end
      endcase
      if (nph != m_ph) begin
        m_wait = 0;
        m_held = 0;
      end
      m_ph = nph;
    end
    e_grant = (!rst && nph == P_HELD) ? N'(1) << m_own : '0;
    e_set = !rst && nph == P_SET;
    e_rst = !rst && (nph == P_INIT || nph == P_CLR);
    e_busy = rst || nph != P_IDLE;
    e_to = !rst && to;
    e_fault = !rst && nph == P_FAULT;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    check("grant", 32'(grant), 32'(e_grant));
    check("lock_set", 32'(lock_set), 32'(e_set));
    check("lock_rst", 32'(lock_rst), 32'(e_rst));
    check("busy", 32'(busy), 32'(e_busy));
    check("timeout", 32'(timeout), 32'(e_to));
    check("fault", 32'(fault), 32'(e_fault));
    check("set_and_rst", 32'(lock_set & lock_rst), 32'd0);
    check("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
    check("grant_needs_q", 32'(grant == '0 || latch_q), 32'd1);
    if (!stuck) latch_q = lock_set ? 1'b1 : lock_rst ? 1'b0 : latch_q;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
  endtask
  logic [N-1:0] prev;
  logic [N-1:0] got_q[$];
  logic [N-1:0] fair_exp[5];
  int cnt, run, len;
  initial begin
    fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    latch_q = 1'b1;
    do_reset();
    repeat (6) cyc();
    check("init_idle_busy", 32'(busy), 32'd0);
    check("init_latch_clear", 32'(latch_q), 32'd0);
    req = 4'b0001;
    repeat (2) cyc();
    check("grant_latency", 32'(grant), 32'd1);
    repeat (2) cyc();
    rel = 4'b0001;
    cyc();
    rel = '0;
    req = '0;
    check("release_latency", 32'(grant), 32'd0);
    repeat (6) cyc();
    do_reset();
    repeat (4) cyc();
    req = '1;
    cnt = 0;
    prev = '0;
    got_q.delete();
    for (int t = 0; t < 200 && got_q.size() < 5; t++) begin
      cyc();
      rel = '0;
      if (grant != '0 && prev == '0) got_q.push_back(grant);
      if (grant != '0) begin
        cnt++;
        if (cnt == 2) begin
          rel = grant;
          cnt = 0;
        end
      end
      prev = grant;
    end
    rel = '0;
    req = '0;
    check("fair_count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < got_q.size() && i < 5; i++) check("fair_order", 32'(got_q[i]), 32'(fair_exp[i]));
    repeat (8) cyc();
    req = 4'b0100;
    run = 0;
    len = 0;
    for (int t = 0; t < 80; t++) begin
      cyc();
      if (grant != '0) run++;
      else if (run != 0 && len == 0) len = run;
    end
    check("hold_len", 32'(len), 32'(HOLD_MAX));
    req = '0;
    repeat (8) cyc();
    req = 4'b0100;
    cyc();
    req = 4'b1000;
    for (int t = 0; t < 12; t++) cyc();
    check("withdrawn_then_next", 32'(grant), 32'b1000);
    req = '0;
    repeat (8) cyc();
    do_reset();
    repeat (4) cyc();
    stuck = 1'b1;
    latch_q = 1'b0;
    req = 4'b0001;
    repeat (12) cyc();
    check("stuck_fault", 32'(fault), 32'd1);
    check("stuck_no_set", 32'(lock_set), 32'd0);
    req = '0;
    stuck = 1'b0;
    do_reset();
    repeat (4) cyc();
    check("fault_cleared", 32'(fault), 32'd0);
    for (int t = 0; t < 3000; t++) begin
      req = N'($urandom);
      rel = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      rst = ($urandom_range(0, 399) == 0);
      cyc();
    end
    rst = 1'b0;
    req = '0;
    rel = '0;
    repeat (4) cyc();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sr_lock_arbiter.md
Name: sr_lock_arbiter

Overview:
- Round-robin arbiter that shares one external SR-latch lock (NOR-pair, active-high set/reset inputs) among N requesters.
- Sequences the latch with one-hot set/reset pulses and checks its q feedback.
- Grants exclusive ownership to one requester at a time and enforces a hold timeout.
- Guarantees set and reset are never asserted together, so the latch never enters its forbidden state.

Parameters:
- N, 4, number of requesters (2..8).
- HOLD_MAX, 16, max cycles a grant may be held; 0 disables the hold timeout.
- ACK_MAX, 4, max cycles to wait for lock_q to follow a set/reset pulse.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req  input  N  per-requester lock request (level).
- rel  input  N  per-requester release pulse.
- lock_q  input  1  latch q feedback.
- lock_set  output  1  drive to latch set input.
- lock_rst  output  1  drive to latch reset input.
- grant  output  N  one-hot ownership grant.
- busy  output  1  state != IDLE.
- timeout  output  1  one-cycle pulse on forced hold release.
- fault  output  1  sticky ack-timeout flag.

Behaviour:
- All outputs are registered.
- While rst=1: state=INIT, grant=0, lock_set=0, lock_rst=0, timeout=0, fault=0, rr pointer=N-1, counters=0.
- States: INIT, IDLE, SET, HELD, CLR, FAULT.
- INIT: lock_rst=1 until lock_q sampled 0, then IDLE. Guarantees the latch is cleared after reset.
- IDLE:
  - If any req bit=1, pick the first set bit searching from ptr+1 (wrapping mod N).
  - Latch the winner as owner and go to SET.
  - Otherwise stay in IDLE.
- SET:
  - lock_set=1.
  - On lock_q=1 (sampled at the edge): go to HELD if req[owner]=1, else go to CLR (request withdrawn, no grant issued).
- HELD:
  - grant[owner]=1, lock_set=0.
  - Exit to CLR when rel[owner]=1 or req[owner]=0.
  - rel/req from non-owners are ignored.
- Hold timer:
  - Counts cycles in HELD, starting at 0 on entry.
  - If HOLD_MAX>0 and the count reaches HOLD_MAX-1 with no release, go to CLR and pulse timeout=1 in the first CLR cycle.
- CLR:
  - grant=0, lock_rst=1.
  - On lock_q=0, go to IDLE and set ptr=owner.
- Grant latency: req sampled in IDLE at edge k -> lock_set=1 from k+1 -> grant=1 from k+2, assuming the latch responds within one cycle.
- Release latency: rel at edge k -> grant=0 and lock_rst=1 from k+1.
- Ack timer:
  - Counts cycles in INIT, SET and CLR.
  - If lock_q has not reached its target after ACK_MAX cycles, go to FAULT.
- FAULT: lock_set=0, lock_rst=0, grant=0, fault=1. Exit only via rst.
- Invariants:
  - lock_set & lock_rst is never 1.
  - grant is at most one-hot.
  - grant=1 only while lock_q=1.
  - busy=0 only in IDLE.
- Fairness: with all requesters held high, grants rotate 0,1,...,N-1,0.
- rst asserted mid-HELD: grant drops in the next cycle, then INIT clears the latch.
- Simultaneous rel[owner] and hold-timeout in the same cycle: treat as a normal release (no timeout pulse).

Test Plan:
- Reset with latch initially q=1 -> INIT drives lock_rst=1 until q=0, then IDLE; busy=0, grant=0.
- req=0001 held, rel[0] pulsed after 3 grant cycles -> grant=0001 two cycles after the req edge; lock_rst pulse follows; ptr=0.
- req=1111 held, each owner releases after 2 cycles -> grant sequence 0001,0010,0100,1000,0001; lock_set and lock_rst never high together.
- HOLD_MAX=16, req=0100 held, no rel -> grant held exactly 16 cycles; timeout=1 for one cycle; lock_rst asserted; requester re-granted after a full cycle.
- req[2] dropped while in SET -> no grant issued; goes directly to CLR; other pending req[3] granted next.
- Latch model stuck at q=0 with req=0001 -> lock_set high for ACK_MAX=4 cycles, then FAULT: fault=1, lock_set=0; cleared only by rst.
